// File: rtl/sig_dump_ctrl_if.sv
// Bus bundle for sig_dump_ctrl: SRAM write snoop, one-outstanding read port and signature stream.
// master = the dump controller, slave = RAM / bus / sink environment.
interface sig_dump_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          snoop_we_i;
    logic [AW-1:0] snoop_addr_i;
    logic [DW-1:0] snoop_wdata_i;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          sig_valid_o;
    logic [DW-1:0] sig_data_o;
    logic          sig_ready_i;

    modport master (
        input  snoop_we_i, snoop_addr_i, snoop_wdata_i,
        output mem_req_o, mem_addr_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output sig_valid_o, sig_data_o,
        input  sig_ready_i
    );

    modport slave (
        output snoop_we_i, snoop_addr_i, snoop_wdata_i,
        input  mem_req_o, mem_addr_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  sig_valid_o, sig_data_o,
        output sig_ready_i
    );
endinterface

// File: rtl/sig_dump_ctrl.sv
// Signature dump controller: latches the signature bounds snooped from the SRAM write bus, then on the
// end flag reads the region word by word and streams it out. Optional watchdog macro: SIG_DUMP_TIMEOUT_EN.
module sig_dump_ctrl #(
    parameter int            AW          = 32,
    parameter int            DW          = 32,
    parameter logic [AW-1:0] BEGIN_ADDR  = 32'h8,
    parameter logic [AW-1:0] END_ADDR    = 32'hC,
    parameter logic [AW-1:0] FLAG_ADDR   = 32'h10,
    parameter int            TIMEOUT_CYC = 1024
) (
    input  logic            clk,
    input  logic            rst,
    sig_dump_ctrl_if.master bus,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [15:0]     word_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    state_e        state_r;
    state_e        state_s;
    logic [AW-1:0] begin_r;
    logic [AW-1:0] end_r;
    logic [AW-1:0] ptr_r;
    logic [DW-1:0] data_r;
    logic [15:0]   cnt_r;
    logic [AW:0]   ptr_inc_s;
    logic          flag_hit_s;
    logic          handshake_s;
    logic          tmo_hit_s;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("sig_dump_ctrl: TIMEOUT_CYC must be at least 1");
    end

    // One extra bit so a pointer step past the top of the address space is seen, not wrapped.
    assign ptr_inc_s   = {1'b0, ptr_r} + {{(AW-2){1'b0}}, 3'd4};
    assign flag_hit_s  = bus.snoop_we_i && (bus.snoop_addr_i == FLAG_ADDR)
                         && (bus.snoop_wdata_i == {{(DW-1){1'b0}}, 1'b1});
    assign handshake_s = (state_r == S_OUT) && bus.sig_ready_i;

`ifdef SIG_DUMP_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tmo_r;

    // Watchdog: counts cycles of the current REQ/WAIT visit, restarts on any state change
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_r <= {TW{1'b0}};
        end else if ((state_s != state_r) || ((state_r != S_REQ) && (state_r != S_WAIT))) begin
            tmo_r <= {TW{1'b0}};
        end else begin
            tmo_r <= tmo_r + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    assign tmo_hit_s = ((state_r == S_REQ) || (state_r == S_WAIT)) && (tmo_r == TW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (flag_hit_s) state_s = S_CHECK;
                else            state_s = S_IDLE;
            end
            S_CHECK: begin
                if ((begin_r[1:0] != 2'b00) || (end_r[1:0] != 2'b00)) state_s = S_ERR;
                else if (begin_r >= end_r)                            state_s = S_DONE;
                else                                                  state_s = S_REQ;
            end
            S_REQ: begin
                if (bus.mem_gnt_i)  state_s = S_WAIT;
                else if (tmo_hit_s) state_s = S_ERR;
                else                state_s = S_REQ;
            end
            S_WAIT: begin
                if (bus.mem_rvalid_i) state_s = S_OUT;
                else if (tmo_hit_s)   state_s = S_ERR;
                else                  state_s = S_WAIT;
            end
            S_OUT: begin
                if (bus.sig_ready_i) begin
                    if (ptr_inc_s[AW])                    state_s = S_ERR;
                    else if (ptr_inc_s[AW-1:0] >= end_r)  state_s = S_DONE;
                    else                                  state_s = S_REQ;
                end else begin
                    state_s = S_OUT;
                end
            end
            S_DONE:  state_s = S_DONE;
            S_ERR:   state_s = S_ERR;
            default: state_s = S_IDLE;
        endcase
    end

    // Bounds capture, read pointer, data holding register and delivered-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            begin_r <= {AW{1'b0}};
            end_r   <= {AW{1'b0}};
            ptr_r   <= {AW{1'b0}};
            data_r  <= {DW{1'b0}};
            cnt_r   <= 16'd0;
        end else begin
            if ((state_r == S_IDLE) && bus.snoop_we_i && (bus.snoop_addr_i == BEGIN_ADDR)) begin
                begin_r <= bus.snoop_wdata_i;
            end
            if ((state_r == S_IDLE) && bus.snoop_we_i && (bus.snoop_addr_i == END_ADDR)) begin
                end_r <= bus.snoop_wdata_i;
            end
            if ((state_r == S_CHECK) && (state_s == S_REQ)) begin
                ptr_r <= begin_r;
            end else if (handshake_s && (state_s == S_REQ)) begin
                ptr_r <= ptr_inc_s[AW-1:0];
            end
            if ((state_r == S_WAIT) && bus.mem_rvalid_i) begin
                data_r <= bus.mem_rdata_i;
            end
            if (handshake_s && (cnt_r != 16'hFFFF)) begin
                cnt_r <= cnt_r + 16'd1;
            end
        end
    end

    // Request and valid are also masked by rst so both drop in the cycle reset is raised.
    assign bus.mem_req_o   = (state_r == S_REQ) && !rst;
    assign bus.mem_addr_o  = ptr_r;
    assign bus.sig_valid_o = (state_r == S_OUT) && !rst;
    assign bus.sig_data_o  = data_r;
    assign busy_o          = (state_r == S_CHECK) || (state_r == S_REQ)
                             || (state_r == S_WAIT) || (state_r == S_OUT);
    assign done_o          = (state_r == S_DONE);
    assign err_o           = (state_r == S_ERR);
    assign word_cnt_o      = cnt_r;

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Self-checking bench for sig_dump_ctrl: table of bound pairs, randomized RAM/sink timing and
// randomized regions checked against an arithmetic model, plus hand-written corner sequences.
module tb_sig_dump_ctrl;
    localparam int          AW      = 32;
    localparam int          DW      = 32;
    localparam logic [31:0] A_BEGIN = 32'h8;
    localparam logic [31:0] A_END   = 32'hC;
    localparam logic [31:0] A_FLAG  = 32'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_cnt;

    sig_dump_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    sig_dump_ctrl #(
        .AW(AW), .DW(DW), .BEGIN_ADDR(32'h8), .END_ADDR(32'hC), .FLAG_ADDR(32'h10), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy_o(busy), .done_o(done), .err_o(err), .word_cnt_o(word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] b;
        logic [31:0] e;
        int          n;
        bit          d;
        bit          x;
        bit          chk_n;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          gnt_pct = 100;
    int          rdy_pct = 100;
    int          max_lat = 0;
    int          stall_idx = 0;
    int          stall_left = 0;
    int          stall_hits = 0;
    int          stall_bad = 0;
    int          req_cycles = 0;
    logic [31:0] stall_data;
    logic [31:0] got[$];
    bit          pending = 1'b0;
    int          lat_left = 0;
    logic [31:0] pend_addr;

    // RAM contents as a pure function of the byte address
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        logic [31:0] p;
        p = a * 32'h9E37_79B1;
        return p ^ 32'h5A5A_5A5A;
    endfunction

    // Expected outcome of a dump from the bounds alone
    function automatic void model(input logic [31:0] b, input logic [31:0] e,
                                  output int n, output bit d, output bit x);
        logic [63:0] span;
        if ((b % 32'd4 != 32'd0) || (e % 32'd4 != 32'd0)) begin
            n = 0; d = 1'b0; x = 1'b1;
        end else if (b >= e) begin
            n = 0; d = 1'b1; x = 1'b0;
        end else begin
            span = {32'd0, e} - {32'd0, b};
            n = int'(span / 64'd4); d = 1'b1; x = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM read port: grant with probability gnt_pct, rvalid 1+lat cycles later, stray rvalids otherwise
    initial begin
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'd0;
        forever begin
            @(negedge clk); #1;
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else if (pending) begin
                if (lat_left == 0) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = ram_word(pend_addr);
                    pending          = 1'b0;
                end else begin
                    lat_left--;
                end
            end else if (bus.mem_req_o && ($urandom_range(0, 99) < gnt_pct)) begin
                bus.mem_gnt_i = 1'b1;
                pending       = 1'b1;
                pend_addr     = bus.mem_addr_o;
                lat_left      = int'($urandom_range(0, max_lat));
            end else if ($urandom_range(0, 3) == 0) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = 32'hDEAD_BEEF;
            end
        end
    end

    // Sink and monitor: random ready, optional forced stall, capture of every completed handshake
    initial begin
        bus.sig_ready_i = 1'b0;
        forever begin
            @(negedge clk); #1;
            if ((stall_left > 0) && bus.sig_valid_o && (got.size() == stall_idx)) begin
                if (stall_hits == 0) stall_data = bus.sig_data_o;
                else if (bus.sig_data_o !== stall_data) stall_bad++;
                if (bus.mem_req_o) stall_bad++;
                stall_left--;
                stall_hits++;
                bus.sig_ready_i = 1'b0;
            end else begin
                bus.sig_ready_i = ($urandom_range(0, 99) < rdy_pct);
            end
            #1;
            if (!rst && bus.sig_valid_o && bus.sig_ready_i) got.push_back(bus.sig_data_o);
            if (bus.mem_req_o) req_cycles++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.snoop_we_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got.delete();
        req_cycles = 0;
        stall_left = 0;
    endtask

    task automatic snoop(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.snoop_we_i    = 1'b1;
        bus.snoop_addr_i  = a;
        bus.snoop_wdata_i = d;
        @(negedge clk);
        bus.snoop_we_i    = 1'b0;
    endtask

    task automatic start_dump(input logic [31:0] b, input logic [31:0] e);
        snoop(A_BEGIN, b);
        snoop(A_END, e);
        snoop(A_FLAG, 32'd1);
    endtask

    // Wait for done/err; optionally hammer the snoop bus while busy to prove the bounds are frozen
    task automatic wait_end(input int budget, input bit poke);
        int c = 0;
        while (!(done || err) && (c < budget)) begin
            @(negedge clk);
            c++;
            if (poke && busy && ($urandom_range(0, 3) == 0)) begin
                bus.snoop_we_i = 1'b1;
                case ($urandom_range(0, 2))
                    0:       bus.snoop_addr_i = A_BEGIN;
                    1:       bus.snoop_addr_i = A_END;
                    default: bus.snoop_addr_i = A_FLAG;
                endcase
                bus.snoop_wdata_i = $urandom();
            end else begin
                bus.snoop_we_i = 1'b0;
            end
        end
        bus.snoop_we_i = 1'b0;
        check("dump_terminates", 64'(done | err), 64'd1);
    endtask

    task automatic verify(input string tag, input logic [31:0] b, input int exp_n,
                          input bit exp_d, input bit exp_x, input bit chk_n);
        check({tag, "_done"}, 64'(done), 64'(exp_d));
        check({tag, "_err"},  64'(err),  64'(exp_x));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        if (chk_n) begin
            check({tag, "_word_cnt"}, 64'(word_cnt), 64'(exp_n));
            check({tag, "_words_seen"}, 64'(got.size()), 64'(exp_n));
        end
        for (int i = 0; (i < exp_n) && (i < got.size()); i++) begin
            check({tag, "_data"}, 64'(got[i]), 64'(ram_word(b + 32'(4 * i))));
        end
    endtask

    initial begin
        vec_t        tbl[8];
        logic [31:0] b;
        logic [31:0] e;
        int          n;
        bit          d;
        bit          x;

        tbl[0] = '{32'h0000_0100, 32'h0000_0110, 4, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h0000_0200, 32'h0000_0200, 0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{32'h0000_0300, 32'h0000_0200, 0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{32'h0000_0102, 32'h0000_0110, 0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{32'h0000_0100, 32'h0000_0112, 0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{32'h0000_0400, 32'h0000_0404, 1, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{32'hFFFF_FFF0, 32'hFFFF_FFFC, 3, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        bus.snoop_we_i    = 1'b0;
        bus.snoop_addr_i  = 32'd0;
        bus.snoop_wdata_i = 32'd0;
        do_reset();

        check("rst_busy",     64'(busy), 64'd0);
        check("rst_done",     64'(done), 64'd0);
        check("rst_err",      64'(err), 64'd0);
        check("rst_word_cnt", 64'(word_cnt), 64'd0);
        check("rst_mem_req",  64'(bus.mem_req_o), 64'd0);
        check("rst_sig_valid", 64'(bus.sig_valid_o), 64'd0);
        check("rst_sig_data", 64'(bus.sig_data_o), 64'd0);

        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                gnt_pct = 100; rdy_pct = 100; max_lat = 0;
            end else begin
                gnt_pct = int'($urandom_range(30, 100));
                rdy_pct = int'($urandom_range(30, 100));
                max_lat = int'($urandom_range(0, 3));
            end
            do_reset();
            start_dump(tbl[i].b, tbl[i].e);
            wait_end(2000, 1'b1);
            verify($sformatf("tbl%0d", i), tbl[i].b, tbl[i].n, tbl[i].d, tbl[i].x, tbl[i].chk_n);
            if (i == 3 || i == 4) check($sformatf("tbl%0d_no_req", i), 64'(req_cycles), 64'd0);
        end

        for (int r = 0; r < 20; r++) begin
            gnt_pct = int'($urandom_range(20, 100));
            rdy_pct = int'($urandom_range(20, 100));
            max_lat = int'($urandom_range(0, 4));
            b = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
            e = b + (32'($urandom_range(0, 8)) << 2);
            case ($urandom_range(0, 7))
                0:       b = b | 32'($urandom_range(1, 3));
                1:       e = b - (32'($urandom_range(1, 4)) << 2);
                default: e = e;
            endcase
            model(b, e, n, d, x);
            do_reset();
            if ($urandom_range(0, 1) == 1) snoop(A_FLAG, 32'($urandom_range(2, 255)));
            start_dump(b, e);
            wait_end(3000, 1'b1);
            verify($sformatf("rnd%0d", r), b, n, d, x, 1'b1);
        end

        // Empty region: done two cycles after the flag, no reads; DONE then ignores a new dump request
        gnt_pct = 100; rdy_pct = 100; max_lat = 0;
        do_reset();
        snoop(A_BEGIN, 32'h200);
        snoop(A_END, 32'h200);
        snoop(A_FLAG, 32'd1);
        check("empty_check_busy", 64'(busy), 64'd1);
        check("empty_check_done", 64'(done), 64'd0);
        @(negedge clk);
        check("empty_done", 64'(done), 64'd1);
        check("empty_busy", 64'(busy), 64'd0);
        start_dump(32'h100, 32'h110);
        repeat (10) @(negedge clk);
        check("done_sticky", 64'(done), 64'd1);
        check("done_idle_busy", 64'(busy), 64'd0);
        check("done_no_req", 64'(req_cycles), 64'd0);
        check("done_word_cnt", 64'(word_cnt), 64'd0);

        // Sink stalls 5 cycles on the second word
        do_reset();
        stall_idx = 1; stall_left = 5; stall_hits = 0; stall_bad = 0;
        start_dump(32'h100, 32'h110);
        wait_end(500, 1'b0);
        verify("stall", 32'h100, 4, 1'b1, 1'b0, 1'b1);
        check("stall_cycles", 64'(stall_hits), 64'd5);
        check("stall_hold_violations", 64'(stall_bad), 64'd0);
        check("stall_req_cycles", 64'(req_cycles), 64'd4);

        // Non-1 flag is ignored, then a real flag starts the dump
        do_reset();
        snoop(A_BEGIN, 32'h100);
        snoop(A_END, 32'h110);
        snoop(A_FLAG, 32'd2);
        repeat (5) @(negedge clk);
        check("flag2_busy", 64'(busy), 64'd0);
        check("flag2_no_req", 64'(req_cycles), 64'd0);
        snoop(A_FLAG, 32'd1);
        check("flag1_busy", 64'(busy), 64'd1);
        wait_end(500, 1'b0);
        verify("flag1", 32'h100, 4, 1'b1, 1'b0, 1'b1);

        // Reset while a word is offered: valid and request drop at once, nothing is delivered
        do_reset();
        rdy_pct = 0;
        start_dump(32'h100, 32'h110);
        for (int c = 0; (c < 100) && !bus.sig_valid_o; c++) @(negedge clk);
        check("rm_reached_out", 64'(bus.sig_valid_o), 64'd1);
        rst = 1'b1;
        #1;
        check("rm_valid_now", 64'(bus.sig_valid_o), 64'd0);
        check("rm_req_now", 64'(bus.mem_req_o), 64'd0);
        @(negedge clk);
        check("rm_busy", 64'(busy), 64'd0);
        check("rm_valid", 64'(bus.sig_valid_o), 64'd0);
        check("rm_word_cnt", 64'(word_cnt), 64'd0);
        check("rm_words_seen", 64'(got.size()), 64'd0);
        rst = 1'b0;
        rdy_pct = 100;
        got.delete();
        req_cycles = 0;
        snoop(A_FLAG, 32'd1);
        wait_end(50, 1'b0);
        verify("rm_bounds_cleared", 32'h0, 0, 1'b1, 1'b0, 1'b1);
        check("rm_bounds_no_req", 64'(req_cycles), 64'd0);

        // Grant never comes
        do_reset();
        gnt_pct = 0;
        start_dump(32'h100, 32'h110);
        repeat (40) @(negedge clk);
`ifdef SIG_DUMP_TIMEOUT_EN
        check("tmo_err", 64'(err), 64'd1);
        check("tmo_busy", 64'(busy), 64'd0);
        check("tmo_req_dropped", 64'(bus.mem_req_o), 64'd0);
        check("tmo_req_cycles", 64'(req_cycles), 64'd16);
`else
        check("notmo_err", 64'(err), 64'd0);
        check("notmo_busy", 64'(busy), 64'd1);
        check("notmo_req_held", 64'(bus.mem_req_o), 64'd1);
        check("notmo_addr", 64'(bus.mem_addr_o), 64'h100);
`endif
        gnt_pct = 100;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
